tagged_accumulator_rr: RTL and testbench

- Multi-flow tagged accumulator.
- Each flow (flux) has its own accumulator and operation counter.
- Every accepted step sums the payloads of all input ports of one flux into that flux's accumulator. After NUM_OP steps it emits one tagged result word.
- Fluxes are served round-robin rather than by fixed priority.
- A registered one-word output stage absorbs back-pressure, so partial steps keep running while a result waits.
- The block sits between per-port input FIFOs and a downstream output FIFO in the dataflow actor library.

---
 rtl/tagged_accumulator_rr.sv | 151 +++++++++++++++
 tb/tb_tagged_accumulator_rr.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tagged_accumulator_rr.sv
// Multi-flux tagged accumulator with a round-robin grant and a one-word output stage.
// Optional macro SATURATE_EN: port and accumulator additions clamp instead of wrapping.

module tagged_acc_lane #(
  parameter int PAYLOAD = 7,
  parameter int CNT_W   = 2,
  parameter int NUM_OP  = 4
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               flush,
  input  logic               grant,
  input  logic [PAYLOAD-1:0] sum,
  output logic [PAYLOAD-1:0] acc_n,
  output logic               last
);
  logic [PAYLOAD-1:0] acc;
  logic [CNT_W-1:0]   cnt;

`ifdef SATURATE_EN
  logic [PAYLOAD:0] acc_w;
  assign acc_w = {1'b0, acc} + {1'b0, sum};
  assign acc_n = acc_w[PAYLOAD] ? '1 : acc_w[PAYLOAD-1:0];
`else
  assign acc_n = acc + sum;
`endif

  assign last = (cnt == CNT_W'(NUM_OP - 1));

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (grant) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_n;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module tagged_accumulator_rr #(
  parameter int PORTS  = 2,
  parameter int FLUX   = 2,
  parameter int WIDTH  = 8,
  parameter int NUM_OP = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH*PORTS-1:0] in_data,
  input  logic [PORTS*FLUX-1:0]  in_empty,
  output logic [PORTS*FLUX-1:0]  in_read,
  input  logic                   out0_full,
  output logic                   out0_wr,
  output logic [WIDTH-1:0]       out0_data
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int PAYLOAD   = WIDTH - TAG_WIDTH;
  localparam int CNT_W     = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;

  logic [FLUX-1:0]              eligible, grantable, last, gnt_vec, rot;
  logic [FLUX-1:0][PAYLOAD-1:0] acc_n;
  logic [PAYLOAD-1:0]           sum;
  logic [TAG_WIDTH-1:0]         ptr, gnt_idx;
  logic                         any_gnt, slot_ok, pend_v;
  logic [WIDTH-1:0]             pend_data;
  logic [PORTS*TAG_WIDTH-1:0]   unused_tag_bits;

  assign out0_wr   = pend_v & ~out0_full;
  assign out0_data = pend_data;
  assign slot_ok   = ~pend_v | out0_wr;

  for (genvar f = 0; f < FLUX; f++) begin : g_flux
    assign eligible[f]  = ~|in_empty[f*PORTS +: PORTS];
    // A completing step needs the output slot; partial steps never do.
    assign grantable[f] = eligible[f] & (slot_ok | ~last[f]) & ~flush & ~rst;
    assign gnt_vec[f]   = any_gnt & (gnt_idx == TAG_WIDTH'(f));
    assign in_read[f*PORTS +: PORTS] = {PORTS{gnt_vec[f]}};
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_tag
    assign unused_tag_bits[p*TAG_WIDTH +: TAG_WIDTH] = in_data[p*WIDTH+PAYLOAD +: TAG_WIDTH];
  end

`ifdef SATURATE_EN
  logic [PAYLOAD:0] sum_w;
  always_comb begin
    sum   = '0;
    sum_w = '0;
    for (int p = 0; p < PORTS; p++) begin
      sum_w = {1'b0, sum} + {1'b0, in_data[p*WIDTH +: PAYLOAD]};
      sum   = sum_w[PAYLOAD] ? '1 : sum_w[PAYLOAD-1:0];
    end
  end
`else
  always_comb begin
    sum = '0;
    for (int p = 0; p < PORTS; p++) sum = sum + in_data[p*WIDTH +: PAYLOAD];
  end
`endif

  // Rotate so bit 0 is the flux just after ptr; first set bit wins.
  assign rot = FLUX'({grantable, grantable} >> ({1'b0, ptr} + (TAG_WIDTH+1)'(1)));

  always_comb begin
    any_gnt = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < FLUX; j++) begin
      if (!any_gnt && rot[j]) begin
        any_gnt = 1'b1;
        gnt_idx = TAG_WIDTH'((int'(ptr) + 1 + j) % FLUX);
      end
    end
  end

  tagged_acc_lane #(.PAYLOAD(PAYLOAD), .CNT_W(CNT_W), .NUM_OP(NUM_OP)) u_lane [FLUX-1:0] (
    .ck    (ck),
    .rst   (rst),
    .flush (flush),
    .grant (gnt_vec),
    .sum   (sum),
    .acc_n (acc_n),
    .last  (last)
  );

  // A refill in the same cycle as a drain keeps pend_v set with the new word.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      ptr       <= TAG_WIDTH'(FLUX - 1);
      pend_v    <= 1'b0;
      pend_data <= '0;
    end else begin
      if (out0_wr) pend_v <= 1'b0;
      if (any_gnt) begin
        ptr <= gnt_idx;
        if (last[gnt_idx]) begin
          pend_v    <= 1'b1;
          pend_data <= {gnt_idx, acc_n[gnt_idx]};
        end
      end
    end
  end
endmodule

// File: tb/tb_tagged_accumulator_rr.sv
// Directed table-driven bench for tagged_accumulator_rr at default parameters.
module tb_tagged_accumulator_rr;
  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_empty = 4'b1111;
  logic [3:0]  in_read;
  logic        out0_full = 1'b0;
  logic        out0_wr;
  logic [7:0]  out0_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        fl;
    logic [3:0]  empty;
    logic [15:0] data;
    logic        full;
    logic [3:0]  exp_read;
    logic        exp_wr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  tagged_accumulator_rr #(.PORTS(2), .FLUX(2), .WIDTH(8), .NUM_OP(4)) dut (
    .ck(ck), .rst(rst), .flush(flush), .in_data(in_data), .in_empty(in_empty),
    .in_read(in_read), .out0_full(out0_full), .out0_wr(out0_wr), .out0_data(out0_data)
  );

  always #5 ck = ~ck;

  function automatic vec_t mk(logic fl, logic [3:0] e, logic [15:0] d, logic fu,
                              logic [3:0] r, logic w, logic [7:0] od);
    vec_t v;
    v.fl = fl; v.empty = e; v.data = d; v.full = fu;
    v.exp_read = r; v.exp_wr = w; v.exp_data = od;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    flush = v.fl; in_empty = v.empty; in_data = v.data; out0_full = v.full;
  endtask

  task automatic check(input string nm, input vec_t v);
    checks++;
    if (in_read !== v.exp_read) begin
      errors++;
      $display("FAIL %s in_read got=%b want=%b", nm, in_read, v.exp_read);
    end
    checks++;
    if (out0_wr !== v.exp_wr) begin
      errors++;
      $display("FAIL %s out0_wr got=%b want=%b", nm, out0_wr, v.exp_wr);
    end
    checks++;
    if (out0_data !== v.exp_data) begin
      errors++;
      $display("FAIL %s out0_data got=%h want=%h", nm, out0_data, v.exp_data);
    end
  endtask

  // Drive just after a rising edge, check mid-cycle, advance one cycle.
  task automatic run(input string nm, input vec_t v);
    drive(v);
    #4;
    check(nm, v);
    @(posedge ck);
    #1;
  endtask

  initial begin
    logic [7:0] ov;
`ifdef SATURATE_EN
    ov = 8'hFF;
`else
    ov = 8'hA0;
`endif
    // single flux: 1+2 per step, four steps -> 0x0C
    repeat (4) vecs.push_back(mk(0, 4'b1100, 16'h0201, 0, 4'b0011, 0, 8'h00));
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 1, 8'h0C));
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 0, 8'h0C));
    // round-robin from ptr=0: flux1 first, then alternating
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(0, 4'b0000, 16'h0201, 0, 4'b1100, 0, 8'h0C));
      vecs.push_back(mk(0, 4'b0000, 16'h0201, 0, 4'b0011, 0, 8'h0C));
    end
    vecs.push_back(mk(0, 4'b0000, 16'h0201, 0, 4'b1100, 0, 8'h0C));
    vecs.push_back(mk(0, 4'b0000, 16'h0201, 0, 4'b0011, 1, 8'h8C)); // drain + refill
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 1, 8'h0C));
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 0, 8'h0C));
    // overflow on flux 1: 100+100 per step
    repeat (4) vecs.push_back(mk(0, 4'b0011, 16'h6464, 0, 4'b1100, 0, 8'h0C));
    vecs.push_back(mk(0, 4'b1111, 16'h6464, 0, 4'b0000, 1, ov));
    vecs.push_back(mk(0, 4'b1111, 16'h6464, 0, 4'b0000, 0, ov));
    // back-pressure: flux0 to cnt=3, flux1 completes into held slot
    repeat (3) vecs.push_back(mk(0, 4'b1100, 16'h0101, 1, 4'b0011, 0, ov));
    repeat (4) vecs.push_back(mk(0, 4'b0011, 16'h0101, 1, 4'b1100, 0, ov));
    repeat (2) vecs.push_back(mk(0, 4'b0000, 16'h0101, 1, 4'b1100, 0, 8'h88));
    vecs.push_back(mk(0, 4'b1100, 16'h0101, 1, 4'b0000, 0, 8'h88));
    vecs.push_back(mk(0, 4'b1111, 16'h0101, 0, 4'b0000, 1, 8'h88));
    vecs.push_back(mk(0, 4'b1100, 16'h0101, 0, 4'b0011, 0, 8'h88));
    vecs.push_back(mk(0, 4'b1111, 16'h0101, 0, 4'b0000, 1, 8'h08));
    // flush with a word pending
    repeat (2) vecs.push_back(mk(0, 4'b0011, 16'h0101, 1, 4'b1100, 0, 8'h08));
    vecs.push_back(mk(0, 4'b1100, 16'h0101, 1, 4'b0011, 0, 8'h88));
    vecs.push_back(mk(1, 4'b0000, 16'h0101, 1, 4'b0000, 0, 8'h88));
    vecs.push_back(mk(1, 4'b0000, 16'h0101, 0, 4'b0000, 1, 8'h88));
    repeat (4) vecs.push_back(mk(0, 4'b1100, 16'h0201, 0, 4'b0011, 0, 8'h88));
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 1, 8'h0C));
    vecs.push_back(mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 0, 8'h0C));

    // reset state, with inputs eligible so in_read gating is exercised
    in_empty = 4'b1100;
    #2;
    check("reset", mk(0, 4'b1100, 16'h0, 0, 4'b0000, 0, 8'h00));
    @(posedge ck); #1;
    rst = 1'b0;
    in_empty = 4'b1111;
    @(posedge ck); #1;

    for (int i = 0; i < vecs.size(); i++) run($sformatf("v%0d", i), vecs[i]);

    // reset mid-accumulation with a word pending and draining
    repeat (4) run("rst_fill", mk(0, 4'b0011, 16'h0101, 1, 4'b1100, 0, 8'h0C));
    repeat (2) run("rst_part", mk(0, 4'b1100, 16'h0201, 1, 4'b0011, 0, 8'h88));
    drive(mk(0, 4'b1100, 16'h0201, 0, 4'b0000, 0, 8'h00));
    #2;
    check("pre_rst", mk(0, 4'b1100, 16'h0201, 0, 4'b0011, 1, 8'h88));
    rst = 1'b1;
    #1;
    check("in_rst", mk(0, 4'b1100, 16'h0201, 0, 4'b0000, 0, 8'h00));
    @(posedge ck); #1;
    rst = 1'b0;
    repeat (4) run("post_rst", mk(0, 4'b1100, 16'h0201, 0, 4'b0011, 0, 8'h00));
    run("post_rst_out", mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 1, 8'h0C));
    run("post_rst_idle", mk(0, 4'b1111, 16'h0201, 0, 4'b0000, 0, 8'h0C));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
